pipe_stage_hs: RTL
==================

// Module: pipe_stage_hs
// PURPOSE
//  Generic pipeline stage register with valid/ready handshake, stall, flush and bubble clearing.
//  Parametrised successor of the fixed-field stage registers (IF/ID .. MEM/WB): one instance per
//  stage boundary, with the stage's fields concatenated onto ctrl/data buses.
//  Adds back-pressure, an optional 2-entry skid buffer for full throughput, flush, and a stall counter.
// PARAMETERS
//  DATA_W  32   width of the datapath payload (alu_c, rdo, pc, inst ... concatenated)
//  CTRL_W  12   width of the control payload (wb_ena, wD_sel, npc_op, wb_reg ...)
//  SKID    1    1 = registered in_ready with 2-entry skid; 0 = single entry, combinational in_ready
//  CLR_BUB 1    1 = out_ctrl is forced to 0 whenever out_valid=0; 0 = out_ctrl holds its last value
//  CNT_W   16   width of the stall counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       kill every entry held in this stage
//  in_valid   in   1       upstream holds a valid instruction
//  in_ready   out  1       stage can accept this cycle
//  in_ctrl    in   CTRL_W  control payload
//  in_data    in   DATA_W  data payload
//  out_valid  out  1       stage output holds a valid instruction (have_inst)
//  out_ready  in   1       downstream accepts this cycle
//  out_ctrl   out  CTRL_W  control payload to the next stage
//  out_data   out  DATA_W  data payload to the next stage
//  stall_cnt  out  CNT_W   saturating count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, stall_cnt=0;
//    in_ready=1 (SKID=1: registered 1; SKID=0: follows the combinational rule).
//  - Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency: an accepted beat appears on out_* on the next rising edge. Order is strictly FIFO.
//  - SKID=0: in_ready = out_ready | ~out_valid (combinational). One entry; throughput is 1/cycle
//    only while downstream is ready.
//  - SKID=1: state machine with EMPTY, BUSY (main valid) and FULL (main + skid valid).
//    in_ready = (state != FULL) and is registered.
//     EMPTY: in_fire -> BUSY (load main).
//     BUSY:  in_fire & out_fire -> BUSY (reload main); in_fire & ~out_fire -> FULL (load skid);
//            ~in_fire & out_fire -> EMPTY.
//     FULL:  out_fire -> BUSY (main <= skid); otherwise hold. in_fire cannot occur.
//  - Flush: on the next edge every entry becomes invalid and the state returns to EMPTY. Flush
//    wins over a simultaneous in_fire, so that beat is dropped. out_data is left unchanged.
//    If CLR_BUB=1, out_ctrl becomes 0.
//  - Bubble: with CLR_BUB=1, out_ctrl is 0 on every cycle with out_valid=0, so wb_ena and
//    similar controls can never leak from a bubble.
//  - stall_cnt: +1 per cycle with out_valid & ~out_ready; saturates at all-ones and never wraps.
//    Cleared only by rst, not by flush.
//  - Payload is stored verbatim; no width conversion. Unused data bits are tied off at the
//    instantiating level.
// STRUCTURE
//  - Shared package pipe_pkg: enum of stage states {ST_EMPTY, ST_BUSY, ST_FULL} (2 bits) and the
//    localparams for ctrl-field offsets used by each stage (WB_ENA_BIT, WD_SEL_LSB, ...).
//  - Sub-module pipe_slot: one valid + {ctrl,data} register with load and clear inputs.
//    The top instantiates two of them (main, skid); the skid slot is generated only when SKID=1.
//  - The stall counter lives in the top; there is no separate module.
// TESTING
//  1 Reset mid-stream: assert rst while state=FULL -> out_valid=0, out_ctrl=0, stall_cnt=0 and
//    in_ready=1 within the same cycle.
//  2 Streaming: SKID=1, out_ready=1, 8 beats data=1..8 back-to-back -> data 1..8 on consecutive
//    cycles, each one cycle after its accept, in_ready stays 1.
//  3 Back-pressure: out_ready=0 for 3 cycles while sending A, B -> out=A held, B in skid,
//    in_ready=0 from the cycle after B; release -> A, B in order, then in_ready=1, stall_cnt=3.
//  4 Flush collision: state BUSY, flush=1 with in_valid=1 (data=0xDEAD) -> next cycle
//    out_valid=0, out_ctrl=0, 0xDEAD never appears.
//  5 SKID=0 mode: out_ready=0 with out_valid=1 -> in_ready=0 combinationally; out_ready=1
//    with in_valid=1 -> passthrough at 1 beat/cycle.
//  6 Saturation: CNT_W=4, out_ready held 0 for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: stage occupancy
// states and the bit positions of the control fields carried on ctrl buses.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_st_e;

   // Control-bus field layout shared by every stage boundary
   localparam int WB_ENA_BIT  = 0;
   localparam int WD_SEL_LSB  = 1;
   localparam int WD_SEL_W    = 2;
   localparam int NPC_OP_LSB  = 3;
   localparam int NPC_OP_W    = 3;
   localparam int WB_REG_LSB  = 6;
   localparam int WB_REG_W    = 5;
   localparam int MEM_WE_BIT  = 11;
   localparam int CTRL_W_STD  = 12;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a valid bit plus a verbatim payload.
// clr takes priority over load; the payload is never touched by clr.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   logic         valid_q, valid_d;
   logic [W-1:0] pay_q, pay_d;

   // next slot contents: load captures the payload, clr only drops validity
   always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      if (load) begin
         valid_d = 1'b1;
         pay_d   = d;
      end
      if (clr) begin
         valid_d = 1'b0;
      end
   end

   // slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pay_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pay_q   <= pay_d;
      end
   end

   assign valid = valid_q;
   assign q     = pay_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush, bubble control clearing and a stall counter.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 12,
   parameter bit SKID    = 1'b1,
   parameter bit CLR_BUB = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = CTRL_W + DATA_W;

   logic [PW-1:0]    in_pay, main_pay, main_d_pay;
   logic             main_valid, main_load, main_clr;
   logic             in_fire, out_fire;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign in_pay   = {in_ctrl, in_data};
   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_valid & out_ready;

   // main slot always drives the stage outputs
   pipe_slot #(.W(PW)) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clr   (main_clr),
      .d     (main_d_pay),
      .valid (main_valid),
      .q     (main_pay)
   );

   generate
      if (SKID) begin : g_skid
         stage_st_e     state_q, state_d;
         logic          in_ready_q, in_ready_d;
         logic          skid_load, skid_clr, skid_valid;
         logic [PW-1:0] skid_pay;

         pipe_slot #(.W(PW)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clr   (skid_clr),
            .d     (in_pay),
            .valid (skid_valid),
            .q     (skid_pay)
         );

         // occupancy FSM: decides which slot loads/clears; flush overrides everything
         always_comb begin
            state_d    = state_q;
            main_load  = 1'b0;
            main_clr   = 1'b0;
            skid_load  = 1'b0;
            skid_clr   = 1'b0;
            main_d_pay = in_pay;
            case (state_q)
               ST_EMPTY: begin
                  if (in_fire) begin
                     main_load = 1'b1;
                     state_d   = ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  if (in_fire && out_fire) begin
                     main_load = 1'b1;
                  end else if (in_fire) begin
                     skid_load = 1'b1;
                     state_d   = ST_FULL;
                  end else if (out_fire) begin
                     main_clr = 1'b1;
                     state_d  = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (out_fire) begin
                     main_load  = 1'b1;
                     main_d_pay = skid_pay;
                     skid_clr   = 1'b1;
                     state_d    = ST_BUSY;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
            if (flush) begin
               main_load = 1'b0;
               skid_load = 1'b0;
               main_clr  = 1'b1;
               skid_clr  = 1'b1;
               state_d   = ST_EMPTY;
            end
            in_ready_d = (state_d != ST_FULL) || skid_valid == 1'b0 && state_d != ST_FULL;
         end

         // state and registered in_ready
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q    <= ST_EMPTY;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q;
      end else begin : g_single
         assign in_ready = out_ready | ~main_valid;

         // single entry: reload on accept, empty when drained, flush drops the beat
         always_comb begin
            main_d_pay = in_pay;
            main_load  = in_fire & ~flush;
            main_clr   = flush | (out_fire & ~in_fire);
         end
      end
   endgenerate

   // saturating count of stalled output cycles; only rst clears it
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // stall counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid;
   assign out_data  = main_pay[DATA_W-1:0];
   assign out_ctrl  = (CLR_BUB && !main_valid) ? '0 : main_pay[PW-1:DATA_W];
   assign stall_cnt = stall_cnt_q;

endmodule
